rsa_core_arbiter: RTL and testbench
===================================

# rsa_core_arbiter

Round-robin scheduler that shares one `Rsa256Core` between `NUM_REQ` independent requesters, such as multiple Avalon wrapper channels. It grants one requester at a time and captures that requester's operands. It then issues a single-cycle start to the core, waits for `o_finished` under a watchdog, and returns the result with a per-requester done pulse. It sits between the wrapper-side channel FSMs and the single core instance.

## Interface
- `WIDTH`, 256: operand and result width, in bits.
- `NUM_REQ`, 2: number of requesters (2–8).
- `TIMEOUT_CYCLES`, 1048576: maximum number of WAIT cycles before an error completion. A value of 0 disables the watchdog.
- `i_clk`  in  1: clock.
- `i_rst_n`  in  1: asynchronous active-low reset.
- `i_req`  in  NUM_REQ: level request, one bit per requester.
- `i_a`, `i_d`, `i_n`  in  NUM_REQ×WIDTH each: packed per-requester operands (base, exponent, modulus).
- `o_done`  out  NUM_REQ: one-cycle completion pulse to the granted requester.
- `o_error`  out  1: marks the current `o_done` pulse as a timeout completion.
- `o_result`  out  WIDTH: last result, held until the next completion.
- `o_busy`  out  1: high in every state except IDLE.
- `o_grant_id`  out  $clog2(NUM_REQ): index of the current or most recent grant.
- `o_core_start`  out  1: start pulse to the core.
- `o_core_a`, `o_core_d`, `o_core_n`  out  WIDTH: captured operands, stable from START until the next grant.
- `i_core_result`  in  WIDTH: core result.
- `i_core_finished`  in  1: core completion pulse.

## Operation
- Reset value of every output is 0. Reset also sets the state to IDLE, the priority pointer to 0 and the watchdog timer to 0.
- **IDLE:**
  - If any `i_req` bit is high, select the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Register that requester's `i_a`/`i_d`/`i_n` into the core operand registers and its index into `o_grant_id`.
  - Go to START.
- **START:** `o_core_start`=1 for exactly this cycle; clear the timer; go to WAIT.
- **WAIT:**
  - If `i_core_finished` is high: capture `i_core_result` into `o_result`, clear the error flag, go to DONE.
  - Else if the watchdog is enabled and timer == `TIMEOUT_CYCLES`-1: set `o_result`=0, set the error flag, go to DONE.
  - Otherwise increment the timer.
  - Finish and timeout in the same cycle resolve as success.
- **DONE:**
  - `o_done[o_grant_id]`=1 and `o_error`=the error flag, for this one cycle.
  - Pointer becomes `o_grant_id`+1, wrapping at NUM_REQ to 0.
  - Go to IDLE.
- **Requester protocol:**
  - Hold `i_req` and stable operands until `o_done` is sampled high.
  - Deassert `i_req` on that same edge.
  - A request still high in the following IDLE cycle is treated as a new request.
- **Protocol violations:**
  - Operands change after capture: ignored.
  - `i_req` dropped before `o_done`: the job runs to completion and still pulses `o_done`.
- `i_core_finished` outside WAIT is ignored.
- Reset asserted mid-operation aborts immediately, with all outputs at reset values. The core shares `i_rst_n`, so it is reset with the arbiter.

## Timing
- Request visible in IDLE at cycle t: grant registered at t+1 (START, `o_core_start` high at t+1). The core starts counting at t+2.
- Core finish at cycle f: `o_done` high at f+1. Next IDLE at f+2.
- Minimum turnaround per job is therefore 4 cycles plus the core latency.
- Timeout completion: `o_done` with `o_error` occurs exactly `TIMEOUT_CYCLES`+1 cycles after START.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,NUM_REQ-1. No requester waits more than NUM_REQ-1 jobs.

## Structure
- Shared package `rsa_pkg` holds:
  - the `RSA_WIDTH`=256 constant;
  - the `arb_state_t` enum (IDLE, START, WAIT, DONE);
  - the Avalon RX/TX/STATUS offsets used across the wrappers.
- Sub-module `rsa_rr_pick`: purely combinational. Inputs are the request vector and pointer; outputs are the valid flag and the winner index. The arbiter contains only the FSM, timer and capture registers.

## Test plan
- Single job, WIDTH=256, behavioral core stub with 20-cycle latency computing a^d mod n:
  - Stimulus: requester 0 with a=5, d=3, n=13.
  - Required: `o_core_start` is one pulse; `o_done`=2'b01 with `o_result`=8 and `o_error`=0, 22 cycles after start.
- Simultaneous requests right after reset:
  - Stimulus: req0 (a=5, d=3, n=13) and req1 (a=7, d=2, n=11).
  - Required: req0 completes first with result 8, then req1 with result 5.
  - `o_grant_id` sequence is 0 then 1; operands on the core match each requester.
- Fairness: both requesters re-request immediately for 6 jobs. Required grant order is 0,1,0,1,0,1.
- Timeout: `TIMEOUT_CYCLES`=16 and a stub that never finishes. Required: `o_done` with `o_error`=1 and `o_result`=0 exactly 17 cycles after START; the next request is served normally.
- Finish on the last WAIT cycle (`TIMEOUT_CYCLES`=16, finish at timer=15). Required: success with `o_error`=0.
- Reset mid-WAIT:
  - Required: all outputs return to 0 and `o_busy`=0.
  - A request after reset release is granted to the lowest active index, pointer=0.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared RSA definitions: datapath width, arbiter states
// and the Avalon register offsets used by the wrappers.
package rsa_pkg;

  localparam int RSA_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } arb_state_t;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;
  localparam int         TX_OK_BIT   = 6;
  localparam int         RX_OK_BIT   = 7;

endpackage

// File: rtl/rsa_core_arbiter_if.sv
// Bundle between the arbiter and the single Rsa256Core:
// start/operands out, result/finished back.
interface rsa_core_arbiter_if #(
  parameter int WIDTH = 256
);

  logic             o_core_start;
  logic [WIDTH-1:0] o_core_a;
  logic [WIDTH-1:0] o_core_d;
  logic [WIDTH-1:0] o_core_n;
  logic [WIDTH-1:0] i_core_result;
  logic             i_core_finished;

  modport master (
    output o_core_start,
    output o_core_a,
    output o_core_d,
    output o_core_n,
    input  i_core_result,
    input  i_core_finished
  );

  modport slave (
    input  o_core_start,
    input  o_core_a,
    input  o_core_d,
    input  o_core_n,
    output i_core_result,
    output i_core_finished
  );

endinterface

// File: rtl/rsa_rr_pick.sv
// Combinational round-robin pick: first set request
// at or after ptr, wrapping modulo N.
module rsa_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  localparam int         NI = N;
  localparam logic [IW:0] NQ = NI[IW:0];

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  always_comb begin
    dbl   = {req, req};
    rot   = N'(dbl >> ptr);
    off   = '0;
    // Downward scan leaves the lowest rotated offset.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    sum   = {1'b0, ptr} + {1'b0, off};
    idx   = (sum >= NQ) ? IW'(sum - NQ) : IW'(sum);
    valid = |req;
  end

endmodule

// File: rtl/rsa_core_arbiter.sv
// Round-robin scheduler sharing one Rsa256Core between
// NUM_REQ requesters, with a watchdog on the core.
module rsa_core_arbiter
  import rsa_pkg::*;
#(
  parameter int WIDTH          = RSA_WIDTH,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*WIDTH-1:0] i_a,
  input  logic [NUM_REQ*WIDTH-1:0] i_d,
  input  logic [NUM_REQ*WIDTH-1:0] i_n,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_error,
  output logic [WIDTH-1:0]         o_result,
  output logic                     o_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  rsa_core_arbiter_if.master       core
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] ID_LAST = IW'(NUM_REQ - 1);

  arb_state_t     state;
  logic [IW-1:0]  ptr;
  logic [TW-1:0]  timer;
  logic           pick_vld;
  logic [IW-1:0]  pick_idx;
  logic [NUM_REQ-1:0] gnt_oh;

  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] d_arr [NUM_REQ];
  logic [WIDTH-1:0] n_arr [NUM_REQ];

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      a_arr[k] = i_a[k*WIDTH +: WIDTH];
      d_arr[k] = i_d[k*WIDTH +: WIDTH];
      n_arr[k] = i_n[k*WIDTH +: WIDTH];
    end
  end

  assign gnt_oh = NUM_REQ'(1) << o_grant_id;

  rsa_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (i_req),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state             <= IDLE;
      ptr               <= '0;
      timer             <= '0;
      o_done            <= '0;
      o_error           <= 1'b0;
      o_result          <= '0;
      o_busy            <= 1'b0;
      o_grant_id        <= '0;
      core.o_core_start <= 1'b0;
      core.o_core_a     <= '0;
      core.o_core_d     <= '0;
      core.o_core_n     <= '0;
    end else begin
      core.o_core_start <= 1'b0;
      o_done            <= '0;
      o_error           <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            o_grant_id        <= pick_idx;
            core.o_core_a     <= a_arr[pick_idx];
            core.o_core_d     <= d_arr[pick_idx];
            core.o_core_n     <= n_arr[pick_idx];
            core.o_core_start <= 1'b1;
            o_busy            <= 1'b1;
            state             <= START;
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Finish wins over a coincident timeout.
          if (core.i_core_finished) begin
            o_result <= core.i_core_result;
            o_done   <= gnt_oh;
            state    <= DONE;
          end else if (WD_EN && timer == T_LAST) begin
            o_result <= '0;
            o_done   <= gnt_oh;
            o_error  <= 1'b1;
            state    <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          ptr    <= (o_grant_id == ID_LAST) ? '0
                    : o_grant_id + 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Bench for rsa_core_arbiter: transaction model with per-cycle
// compare on one instance, directed watchdog cases on a second.
module tb_rsa_core_arbiter;
  import rsa_pkg::*;

  localparam int W = 256;
  localparam int N = 2;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] d;
    logic [W-1:0] n;
  } job_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] modexp(
      input logic [W-1:0] a, input logic [W-1:0] d,
      input logic [W-1:0] n);
    longint unsigned b, e, m, r;
    m = 64'(n[31:0]);
    if (m == 0) return '0;
    b = 64'(a[31:0]) % m;
    e = 64'(d[31:0]);
    r = 1 % m;
    while (e != 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return W'(r);
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  function automatic job_t mkjob(input int a, input int d,
                                 input int n);
    job_t j;
    j.a = W'(a);
    j.d = W'(d);
    j.n = W'(n);
    return j;
  endfunction

  function automatic job_t rndjob();
    return mkjob(int'($urandom_range(65535)),
                 int'($urandom_range(40)),
                 int'($urandom_range(65535, 2)));
  endfunction

  // ---------------- instance A: default watchdog ----------------
  logic           rst_a_n;
  logic [N-1:0]   req_a;
  logic [N*W-1:0] a_a, d_a, n_a;
  logic [N-1:0]   done_a;
  logic           err_a, busy_a;
  logic [W-1:0]   res_a;
  logic [0:0]     gid_a;

  rsa_core_arbiter_if #(.WIDTH(W)) cif_a ();

  rsa_core_arbiter #(
    .WIDTH(W), .NUM_REQ(N)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_a_n), .i_req(req_a),
    .i_a(a_a), .i_d(d_a), .i_n(n_a),
    .o_done(done_a), .o_error(err_a), .o_result(res_a),
    .o_busy(busy_a), .o_grant_id(gid_a), .core(cif_a)
  );

  int cnt_a;
  int lat_a = 20;
  bit lat_rand = 0;
  bit noise_a = 0;

  always @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      cnt_a <= 0;
      cif_a.i_core_finished <= 1'b0;
      cif_a.i_core_result <= '0;
    end else begin
      if (cif_a.o_core_start) begin
        cnt_a <= lat_rand ? int'($urandom_range(30, 1)) : lat_a;
        cif_a.i_core_result <= modexp(cif_a.o_core_a,
                                      cif_a.o_core_d, cif_a.o_core_n);
      end else if (cnt_a != 0) begin
        cnt_a <= cnt_a - 1;
      end
      cif_a.i_core_finished <= !cif_a.o_core_start &&
        (cnt_a == 1 ||
         (noise_a && cnt_a == 0 && $urandom_range(7) == 0));
    end
  end

  // ---------------- requester driver for A ----------------
  job_t jq0[$];
  job_t jq1[$];
  bit rr_mode = 1;
  bit chaos = 0;
  logic [N-1:0] mon_done_a = '0;

  task automatic drive_req(input int i);
    job_t j;
    bit have;
    if (mon_done_a[i]) req_a[i] = 1'b0;
    if (chaos && req_a[i]) begin
      if ($urandom_range(63) == 0) req_a[i] = 1'b0;
      else if ($urandom_range(15) == 0)
        a_a[i*W +: W] = W'($urandom_range(65535));
    end
    if (!req_a[i] && (rr_mode || $urandom_range(3) == 0)) begin
      have = 0;
      if (i == 0 && jq0.size() > 0) begin j = jq0.pop_front(); have = 1; end
      if (i == 1 && jq1.size() > 0) begin j = jq1.pop_front(); have = 1; end
      if (have) begin
        a_a[i*W +: W] = j.a;
        d_a[i*W +: W] = j.d;
        n_a[i*W +: W] = j.n;
        req_a[i] = 1'b1;
      end
    end
  endtask

  initial begin
    req_a = '0; a_a = '0; d_a = '0; n_a = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_a_n) req_a = '0;
      else for (int i = 0; i < N; i++) drive_req(i);
    end
  end

  // ---------------- transaction model + compare for A ----------------
  logic [N-1:0] p_req = '0;
  logic [W-1:0] p_a [N];
  logic [W-1:0] p_d [N];
  logic [W-1:0] p_n [N];
  bit p_rst = 0;
  int m_ptr = 0, m_id = 0, m_start = 0;
  int m_due = -1, m_last_done = -10;
  bit m_pend = 0;
  logic [W-1:0] m_res = '0, m_last_res = '0;
  bit exp_start, exp_done;
  int e_id;
  int st_cnt = 0;
  int slog_cyc[$], slog_id[$], dlog_cyc[$], dlog_id[$];
  logic [W-1:0] dlog_res[$];

  always @(negedge clk) begin
    if (!rst_a_n) begin
      m_ptr = 0; m_pend = 0; m_id = 0; m_due = -1;
      m_last_done = -10; m_last_res = '0;
      check("rst_ctl", W'({done_a, err_a, busy_a, gid_a,
                           cif_a.o_core_start}), '0);
      check("rst_result", res_a, '0);
      check("rst_ops", cif_a.o_core_a | cif_a.o_core_d |
                       cif_a.o_core_n, '0);
    end else begin
      exp_start = p_rst && !m_pend && p_req != 0 &&
                  (cyc - 1) > m_last_done;
      check("core_start", W'(cif_a.o_core_start), W'(exp_start));
      if (exp_start) begin
        e_id = pick(p_req, m_ptr);
        check("grant_id", W'(gid_a), W'(e_id));
        check("core_a", cif_a.o_core_a, p_a[e_id]);
        check("core_d", cif_a.o_core_d, p_d[e_id]);
        check("core_n", cif_a.o_core_n, p_n[e_id]);
        m_pend = 1; m_id = e_id; m_start = cyc; m_due = -1;
        m_res = modexp(p_a[e_id], p_d[e_id], p_n[e_id]);
      end
      exp_done = m_pend && cyc == m_due;
      check("done", W'(done_a), exp_done ? W'(1 << m_id) : '0);
      check("error", W'(err_a), '0);
      if (exp_done) begin
        m_last_res = m_res;
        m_pend = 0;
        m_last_done = cyc;
        m_ptr = (m_id + 1) % N;
      end
      check("result", res_a, m_last_res);
      check("busy", W'(busy_a), W'(m_pend || exp_done));
      check("grant_hold", W'(gid_a), W'(m_id));
      if (m_pend && cyc > m_start && m_due < 0 &&
          cif_a.i_core_finished)
        m_due = cyc + 1;
    end
    if (cif_a.o_core_start) begin
      st_cnt++;
      slog_cyc.push_back(cyc);
      slog_id.push_back(int'(gid_a));
    end
    if (done_a != 0) begin
      dlog_cyc.push_back(cyc);
      dlog_id.push_back(int'(gid_a));
      dlog_res.push_back(res_a);
    end
    p_req = req_a;
    p_rst = rst_a_n;
    for (int k = 0; k < N; k++) begin
      p_a[k] = a_a[k*W +: W];
      p_d[k] = d_a[k*W +: W];
      p_n[k] = n_a[k*W +: W];
    end
    mon_done_a = done_a;
  end

  // ---------------- instance B: 16-cycle watchdog ----------------
  logic           rst_b_n;
  logic [N-1:0]   req_b;
  logic [N*W-1:0] a_b, d_b, n_b;
  logic [N-1:0]   done_b;
  logic           err_b, busy_b;
  logic [W-1:0]   res_b;
  logic [0:0]     gid_b;
  int cnt_b;
  int lat_b = 0;

  rsa_core_arbiter_if #(.WIDTH(W)) cif_b ();

  rsa_core_arbiter #(
    .WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYCLES(16)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_b_n), .i_req(req_b),
    .i_a(a_b), .i_d(d_b), .i_n(n_b),
    .o_done(done_b), .o_error(err_b), .o_result(res_b),
    .o_busy(busy_b), .o_grant_id(gid_b), .core(cif_b)
  );

  always @(posedge clk or negedge rst_b_n) begin
    if (!rst_b_n) begin
      cnt_b <= 0;
      cif_b.i_core_finished <= 1'b0;
      cif_b.i_core_result <= '0;
    end else begin
      if (cif_b.o_core_start) begin
        cnt_b <= lat_b;
        cif_b.i_core_result <= modexp(cif_b.o_core_a,
                                      cif_b.o_core_d, cif_b.o_core_n);
      end else if (cnt_b != 0) begin
        cnt_b <= cnt_b - 1;
      end
      cif_b.i_core_finished <= !cif_b.o_core_start && cnt_b == 1;
    end
  end

  task automatic run_b(input string nm, input job_t j, input int lat,
                       input int exp_dt, input logic exp_err,
                       input logic [W-1:0] exp_res);
    int s, c;
    @(negedge clk);
    lat_b = lat;
    a_b[W-1:0] = j.a; d_b[W-1:0] = j.d; n_b[W-1:0] = j.n;
    req_b = 2'b01;
    s = -1000; c = 0;
    while (s < 0 && c < 10) begin
      @(negedge clk); c++;
      if (cif_b.o_core_start) s = cyc;
    end
    c = 0;
    while (done_b == 0 && c < 40) begin
      @(negedge clk); c++;
    end
    check({nm, "_latency"}, W'(cyc - s), W'(exp_dt));
    check({nm, "_done"}, W'(done_b), W'(2'b01));
    check({nm, "_error"}, W'(err_b), W'(exp_err));
    check({nm, "_result"}, res_b, exp_res);
    @(posedge clk);
    #1 req_b = 2'b00;
    @(negedge clk);
    check({nm, "_pulse"}, W'(done_b), '0);
  endtask

  // ---------------- sequencing helpers ----------------
  task automatic reset_a();
    @(posedge clk);
    #2 rst_a_n = 1'b0;
    jq0.delete();
    jq1.delete();
    repeat (2) @(posedge clk);
    #2 rst_a_n = 1'b1;
  endtask

  task automatic clear_logs();
    slog_cyc.delete(); slog_id.delete();
    dlog_cyc.delete(); dlog_id.delete(); dlog_res.delete();
    st_cnt = 0;
  endtask

  task automatic wait_dones(input string nm, input int k,
                            input int bound);
    int c = 0;
    while (dlog_cyc.size() < k && c < bound) begin
      @(posedge clk); c++;
    end
    check({nm, "_completions"}, W'(dlog_cyc.size()), W'(k));
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int c = 0;
    while (!(jq0.size() == 0 && jq1.size() == 0 && req_a == 0 &&
             !m_pend && cyc > m_last_done + 1) && c < bound) begin
      @(posedge clk); c++;
    end
    check({nm, "_drained"}, W'(c < bound), W'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    req_b = '0; a_b = '0; d_b = '0; n_b = '0;
    check("pin_modexp0", modexp(W'(5), W'(3), W'(13)), W'(8));
    check("pin_modexp1", modexp(W'(7), W'(2), W'(11)), W'(5));
    check("pin_modexp2", modexp(W'(3), W'(4), W'(7)), W'(4));
    @(negedge clk);
    check("b_rst_ctl", W'({done_b, err_b, busy_b, gid_b,
                           cif_b.o_core_start}), '0);
    check("b_rst_result", res_b, '0);
    repeat (2) @(posedge clk);
    #2 rst_a_n = 1'b1; rst_b_n = 1'b1;

    // single job, 20-cycle core
    clear_logs();
    jq0.push_back(mkjob(5, 3, 13));
    wait_dones("t1", 1, 100);
    repeat (2) @(posedge clk);
    check("t1_start_pulses", W'(st_cnt), W'(1));
    if (dlog_cyc.size() > 0 && slog_cyc.size() > 0) begin
      check("t1_latency", W'(dlog_cyc[0] - slog_cyc[0]), W'(22));
      check("t1_result", dlog_res[0], W'(8));
      check("t1_done_id", W'(dlog_id[0]), W'(0));
    end

    // simultaneous requests right after reset
    reset_a();
    clear_logs();
    jq0.push_back(mkjob(5, 3, 13));
    jq1.push_back(mkjob(7, 2, 11));
    wait_dones("t2", 2, 200);
    if (dlog_cyc.size() >= 2 && slog_id.size() >= 2) begin
      check("t2_grant0", W'(slog_id[0]), W'(0));
      check("t2_grant1", W'(slog_id[1]), W'(1));
      check("t2_res0", dlog_res[0], W'(8));
      check("t2_res1", dlog_res[1], W'(5));
    end

    // fairness: both re-request immediately
    repeat (3) @(posedge clk);
    @(negedge clk);
    clear_logs();
    for (int k = 0; k < 3; k++) begin
      jq0.push_back(rndjob());
      jq1.push_back(rndjob());
    end
    wait_dones("t3", 6, 400);
    for (int k = 0; k < 6; k++) begin
      if (k < slog_id.size())
        check("t3_grant_order", W'(slog_id[k]), W'(k % 2));
    end

    // randomized traffic with protocol noise
    wait_idle("t3", 200);
    chaos = 1; rr_mode = 0; noise_a = 1; lat_rand = 1;
    for (int k = 0; k < 15; k++) begin
      jq0.push_back(rndjob());
      jq1.push_back(rndjob());
    end
    wait_idle("t4", 8000);
    chaos = 0; rr_mode = 1; noise_a = 0; lat_rand = 0;

    // reset mid-WAIT, pointer returns to 0
    @(negedge clk);
    clear_logs();
    jq0.push_back(mkjob(5, 3, 13));
    wait_dones("t5a", 1, 100);
    @(negedge clk);
    clear_logs();
    jq1.push_back(mkjob(7, 2, 11));
    begin
      int c = 0;
      while (slog_cyc.size() == 0 && c < 50) begin
        @(posedge clk); c++;
      end
      check("t5_started", W'(slog_cyc.size()), W'(1));
    end
    repeat (8) @(posedge clk);
    #2 rst_a_n = 1'b0;
    jq0.delete(); jq1.delete();
    @(negedge clk);
    check("t5_rst_busy", W'(busy_a), '0);
    check("t5_rst_result", res_a, '0);
    @(posedge clk);
    #2 rst_a_n = 1'b1;
    clear_logs();
    jq0.push_back(mkjob(3, 4, 7));
    jq1.push_back(mkjob(7, 2, 11));
    wait_dones("t5", 2, 200);
    if (slog_id.size() >= 2 && dlog_res.size() >= 2) begin
      check("t5_first_grant", W'(slog_id[0]), W'(0));
      check("t5_res0", dlog_res[0], W'(4));
      check("t5_res1", dlog_res[1], W'(5));
    end

    // watchdog instance
    run_b("b_timeout", mkjob(5, 3, 13), 0, 17, 1'b1, '0);
    run_b("b_normal", mkjob(7, 2, 11), 5, 7, 1'b0, W'(5));
    run_b("b_last_wait", mkjob(3, 4, 7), 15, 17, 1'b0, W'(4));

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
